// File: rtl/mac_simd_pipe.sv
// mac_simd_pipe: two-stage signed MAC with guard bits, saturation and dual-lane SIMD mode.
module mac_simd_pipe #(
  parameter int DW    = 16,
  parameter int GUARD = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                in_valid,
  input  logic [2:0]          instruction,
  input  logic [DW-1:0]       multiplier,
  input  logic [DW-1:0]       multiplicand,
  output logic [2*DW-1:0]     result,
  output logic [GUARD-1:0]    protect,
  output logic                out_valid,
  output logic [1:0]          sat_flag
);
  localparam int AW = 2*DW + GUARD;
  localparam int GH = GUARD/2;
  localparam int HW = DW/2;
  localparam int LW = DW + GH;

  // Returns {clamp flag, next lane value} for one SIMD lane.
  function automatic logic [LW:0] lane_step(input logic [1:0] op, input logic [LW-1:0] l,
                                            input logic [HW-1:0] a, input logic [HW-1:0] b);
    logic [DW-1:0] p;
    logic [LW-1:0] pe;
    logic pos, neg;
    p   = {{HW{a[HW-1]}}, a} * {{HW{b[HW-1]}}, b};
    pe  = {{GH{p[DW-1]}}, p};
    pos = ~l[LW-1] & |l[LW-2:DW-1];
    neg = l[LW-1] & ~&l[LW-2:DW-1];
    return op == 2'd0 ? {(LW+1){1'b0}} :
           op == 2'd1 ? {1'b0, pe} :
           op == 2'd2 ? {1'b0, l + pe} :
           pos        ? {1'b1, {(GH+1){1'b0}}, {(DW-1){1'b1}}} :
           neg        ? {1'b1, {(GH+1){1'b1}}, {(DW-1){1'b0}}} :
                        {1'b0, l};
  endfunction

  logic          s1_v;
  logic [2:0]    s1_ins;
  logic [DW-1:0] s1_a, s1_b;
  logic [AW-1:0] acc, acc_nxt, full_nxt, fpe;
  logic [2*DW-1:0] fp;
  logic [LW:0]   r1, r0;
  logic [1:0]    op, flags, flag_nxt;
  logic          fpos, fneg;

  assign {protect, result} = acc;
  assign op   = s1_ins[1:0];
  assign fp   = {{DW{s1_a[DW-1]}}, s1_a} * {{DW{s1_b[DW-1]}}, s1_b};
  assign fpe  = {{GUARD{fp[2*DW-1]}}, fp};
  assign fpos = ~acc[AW-1] & |acc[AW-2:2*DW-1];
  assign fneg = acc[AW-1] & ~&acc[AW-2:2*DW-1];

  always_comb begin
    full_nxt = op == 2'd0 ? {AW{1'b0}} :
               op == 2'd1 ? fpe :
               op == 2'd2 ? acc + fpe :
               fpos       ? {{(GUARD+1){1'b0}}, {(2*DW-1){1'b1}}} :
               fneg       ? {{(GUARD+1){1'b1}}, {(2*DW-1){1'b0}}} :
                            acc;
    r1 = lane_step(op, {acc[AW-1:AW-GH], acc[2*DW-1:DW]}, s1_a[DW-1:HW], s1_b[DW-1:HW]);
    r0 = lane_step(op, {acc[2*DW+GH-1:2*DW], acc[DW-1:0]}, s1_a[HW-1:0], s1_b[HW-1:0]);
    acc_nxt  = s1_ins[2] ? {r1[LW-1:DW], r0[LW-1:DW], r1[DW-1:0], r0[DW-1:0]} : full_nxt;
    flags    = s1_ins[2] ? {r1[LW], r0[LW]} : {2{(op == 2'd3) & (fpos | fneg)}};
    flag_nxt = op == 2'd0 ? 2'b00 : sat_flag | flags;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v      <= 1'b0;
      s1_ins    <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      sat_flag  <= '0;
    end else if (!stall) begin
      s1_v      <= in_valid;
      s1_ins    <= instruction;
      s1_a      <= multiplier;
      s1_b      <= multiplicand;
      out_valid <= s1_v;
      if (s1_v) begin
        acc      <= acc_nxt;
        sat_flag <= flag_nxt;
      end
    end
  end
endmodule
